// File: rtl/mem_pkg.sv
// Load-path encodings shared by the MEM-stage load unit and its extractor.
package mem_pkg;

    localparam logic [1:0] LT_BYTE     = 2'b00;
    localparam logic [1:0] LT_HALF     = 2'b01;
    localparam logic [1:0] LT_WORD     = 2'b10;
    localparam int         LT_UNSIGNED = 2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } loadState_t;

    // Type 2'b11 behaves as a word everywhere.
    function automatic logic [1:0] busSize(input logic [1:0] width);
        case (width)
            LT_BYTE: busSize = SZ_BYTE;
            LT_HALF: busSize = SZ_HALF;
            default: busSize = SZ_WORD;
        endcase
    endfunction

    function automatic logic isMisaligned(input logic [1:0] width, input logic [1:0] off);
        case (width)
            LT_BYTE: isMisaligned = 1'b0;
            LT_HALF: isMisaligned = off[0];
            default: isMisaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/halfword of a returned word and sign- or zero-extends it.
module load_extract
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  loadType,
    output logic [31:0] result
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic        signFill;

    always_comb begin
        byteVal = 8'h00;
        case (off)
            2'd0: byteVal = rdata[7:0];
            2'd1: byteVal = rdata[15:8];
            2'd2: byteVal = rdata[23:16];
            default: byteVal = rdata[31:24];
        endcase
        halfVal = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        signFill = 1'b0;
        result   = rdata;
        case (loadType[1:0])
            LT_BYTE: begin
                signFill = ~loadType[LT_UNSIGNED] & byteVal[7];
                result   = {{24{signFill}}, byteVal};
            end
            LT_HALF: begin
                signFill = ~loadType[LT_UNSIGNED] & halfVal[15];
                result   = {{16{signFill}}, halfVal};
            end
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/data_load_unit.sv
// Issues MEM-stage loads on the req/addr_ok/data_ok bus, stalls until data returns,
// and hands the extended result to writeback for one cycle.
//   state | meaning
//   IDLE  | no load in flight; accepts a new load
//   REQ   | data_req high, waiting for addr_ok
//   WAIT  | address accepted, waiting for data_ok
//   DONE  | result presented to writeback for one cycle
module data_load_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [2:0]        load_type,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [3:0]        exception_in,
    input  logic              flush,
    output logic              stall_out,
    output logic              adel_out,
    output logic [31:0]       load_data_out,
    output logic              load_data_valid,
    output logic              data_req,
    output logic [ADDR_W-1:0] data_addr,
    output logic [1:0]        data_size,
    input  logic              data_addr_ok,
    input  logic [31:0]       data_rdata,
    input  logic              data_data_ok
);

    loadState_t  state, nextState;
    logic [2:0]  typeReg;
    logic        killed;
    logic        killNow;
    logic        misaligned;
    logic        start;
    logic        beatDone;
    logic        capture;
    logic [31:0] extracted;

    assign misaligned = isMisaligned(load_type[1:0], load_addr[1:0]);
    assign start      = load_valid & (exception_in == 4'h0) & ~misaligned & ~flush
                        & (state == ST_IDLE);
    // A flush arriving on the same cycle as the data beat still discards it.
    assign killNow    = killed | flush;
    assign beatDone   = data_data_ok & (((state == ST_REQ) & data_addr_ok) | (state == ST_WAIT));
    assign capture    = beatDone & ~killNow;

    load_extract uExtract (
        .rdata    (data_rdata),
        .off      (data_addr[1:0]),
        .loadType (typeReg),
        .result   (extracted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: if (start) nextState = ST_REQ;
            ST_REQ: begin
                if (data_addr_ok) begin
                    if (data_data_ok) nextState = killNow ? ST_IDLE : ST_DONE;
                    else              nextState = ST_WAIT;
                end
            end
            ST_WAIT: if (data_data_ok) nextState = killNow ? ST_IDLE : ST_DONE;
            default: nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        data_req        = (state == ST_REQ);
        load_data_valid = (state == ST_DONE);
        stall_out       = start | (state == ST_REQ) | (state == ST_WAIT);
        adel_out        = load_valid & misaligned & (exception_in == 4'h0) & (state == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_addr     <= '0;
            data_size     <= SZ_BYTE;
            typeReg       <= 3'b000;
            killed        <= 1'b0;
            load_data_out <= 32'h0;
        end else begin
            if (start) begin
                data_addr <= load_addr;
                data_size <= busSize(load_type[1:0]);
                typeReg   <= load_type;
            end
            if ((state == ST_REQ) || (state == ST_WAIT)) begin
                if (nextState == ST_IDLE) killed <= 1'b0;
                else if (flush)           killed <= 1'b1;
            end else begin
                killed <= 1'b0;
            end
            if (capture) load_data_out <= extracted;
        end
    end

endmodule

// File: tb/tb_data_load_unit.sv
// Directed bench for data_load_unit: extraction, backpressure, misalignment, flush and async reset.
module tb_data_load_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic [2:0]  load_type;
    logic [31:0] load_addr;
    logic [3:0]  exception_in;
    logic        flush;
    logic        stall_out;
    logic        adel_out;
    logic [31:0] load_data_out;
    logic        load_data_valid;
    logic        data_req;
    logic [31:0] data_addr;
    logic [1:0]  data_size;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    data_load_unit #(.ADDR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .load_valid      (load_valid),
        .load_type       (load_type),
        .load_addr       (load_addr),
        .exception_in    (exception_in),
        .flush           (flush),
        .stall_out       (stall_out),
        .adel_out        (adel_out),
        .load_data_out   (load_data_out),
        .load_data_valid (load_data_valid),
        .data_req        (data_req),
        .data_addr       (data_addr),
        .data_size       (data_size),
        .data_addr_ok    (data_addr_ok),
        .data_rdata      (data_rdata),
        .data_data_ok    (data_data_ok)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one load end to end; addr_ok is withheld holdOff REQ cycles, data_ok
    // comes with addr_ok when sameBeat, otherwise one cycle later.
    task automatic runLoad(input string tag, input logic [2:0] lt, input logic [31:0] addr,
                           input logic [31:0] rd, input int holdOff, input bit sameBeat,
                           input logic [1:0] expSize, input logic [31:0] expData);
        int reqCycles;
        int stallCycles;
        reqCycles   = 0;
        stallCycles = 0;
        load_valid = 1'b1;
        load_type  = lt;
        load_addr  = addr;
        #1;
        check({tag, ":startReq"}, data_req, 1'b0);
        check({tag, ":startAdel"}, adel_out, 1'b0);
        stallCycles += stall_out;
        nextCycle();
        load_valid = 1'b0;
        load_addr  = 32'hDEAD_BEEF;
        for (int i = 0; i < holdOff; i++) begin
            #1;
            reqCycles   += data_req;
            stallCycles += stall_out;
            nextCycle();
        end
        data_addr_ok = 1'b1;
        data_data_ok = sameBeat;
        data_rdata   = rd;
        #1;
        reqCycles   += data_req;
        stallCycles += stall_out;
        check({tag, ":addr"}, data_addr, addr);
        check({tag, ":size"}, {30'd0, data_size}, {30'd0, expSize});
        nextCycle();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        if (!sameBeat) begin
            #1;
            check({tag, ":waitReq"}, data_req, 1'b0);
            stallCycles += stall_out;
            data_data_ok = 1'b1;
            nextCycle();
            data_data_ok = 1'b0;
        end
        data_rdata = 32'h0BAD_F00D;
        #1;
        check({tag, ":doneValid"}, load_data_valid, 1'b1);
        check({tag, ":doneData"}, load_data_out, expData);
        check({tag, ":doneStall"}, stall_out, 1'b0);
        check({tag, ":reqCycles"}, reqCycles, holdOff + 1);
        check({tag, ":stallCycles"}, stallCycles, sameBeat ? holdOff + 2 : holdOff + 3);
        nextCycle();
        check({tag, ":validDrop"}, load_data_valid, 1'b0);
        check({tag, ":dataHold"}, load_data_out, expData);
    endtask

    initial begin
        rst          = 1'b1;
        load_valid   = 1'b0;
        load_type    = 3'b000;
        load_addr    = 32'h0;
        exception_in = 4'h0;
        flush        = 1'b0;
        data_addr_ok = 1'b0;
        data_rdata   = 32'h0;
        data_data_ok = 1'b0;
        #2;
        check("rst:req", data_req, 1'b0);
        check("rst:addr", data_addr, 32'h0);
        check("rst:size", {30'd0, data_size}, 32'h0);
        check("rst:data", load_data_out, 32'h0);
        check("rst:valid", load_data_valid, 1'b0);
        check("rst:stall", stall_out, 1'b0);
        check("rst:adel", adel_out, 1'b0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        nextCycle();

        runLoad("sbyte", 3'b000, 32'h8000_0003, 32'h80FF_1234, 0, 1'b0, 2'd0, 32'hFFFF_FF80);
        runLoad("uhalf", 3'b101, 32'h0000_1002, 32'h8001_ABCD, 0, 1'b0, 2'd1, 32'h0000_8001);
        runLoad("shalf", 3'b001, 32'h0000_1000, 32'h8001_ABCD, 0, 1'b0, 2'd1, 32'hFFFF_ABCD);
        runLoad("ubyte", 3'b100, 32'h0000_1001, 32'h80FF_1234, 0, 1'b0, 2'd0, 32'h0000_0012);
        runLoad("sbyte2", 3'b000, 32'h0000_1002, 32'h80FF_1234, 1, 1'b0, 2'd0, 32'hFFFF_FFFF);
        runLoad("bkpres", 3'b010, 32'h0000_2000, 32'h1234_5678, 4, 1'b1, 2'd2, 32'h1234_5678);
        runLoad("type11", 3'b011, 32'h0000_2004, 32'hCAFE_0001, 0, 1'b1, 2'd2, 32'hCAFE_0001);

        // Misaligned word, then the same with a prior exception.
        load_valid = 1'b1;
        load_type  = 3'b010;
        load_addr  = 32'h0000_0006;
        #1;
        check("misal:adel", adel_out, 1'b1);
        check("misal:stall", stall_out, 1'b0);
        nextCycle();
        check("misal:req", data_req, 1'b0);
        exception_in = 4'h1;
        #1;
        check("misalExc:adel", adel_out, 1'b0);
        check("misalExc:stall", stall_out, 1'b0);
        load_addr = 32'h0000_0004;
        #1;
        check("alignedExc:stall", stall_out, 1'b0);
        nextCycle();
        check("alignedExc:req", data_req, 1'b0);
        exception_in = 4'h0;
        load_valid   = 1'b0;

        // Flush in IDLE suppresses the start.
        load_valid = 1'b1;
        flush      = 1'b1;
        #1;
        check("idleFlush:stall", stall_out, 1'b0);
        nextCycle();
        check("idleFlush:req", data_req, 1'b0);
        load_valid = 1'b0;
        flush      = 1'b0;
        nextCycle();

        // Flush while waiting for data: beat consumed, result discarded.
        load_valid = 1'b1;
        load_type  = 3'b010;
        load_addr  = 32'h0000_3000;
        nextCycle();
        load_valid   = 1'b0;
        data_addr_ok = 1'b1;
        nextCycle();
        data_addr_ok = 1'b0;
        flush        = 1'b1;
        #1;
        check("flushW:stall0", stall_out, 1'b1);
        nextCycle();
        flush = 1'b0;
        #1;
        check("flushW:stall1", stall_out, 1'b1);
        check("flushW:req1", data_req, 1'b0);
        nextCycle();
        data_data_ok = 1'b1;
        data_rdata   = 32'h5555_AAAA;
        #1;
        check("flushW:stall2", stall_out, 1'b1);
        nextCycle();
        data_data_ok = 1'b0;
        #1;
        check("flushW:valid", load_data_valid, 1'b0);
        check("flushW:stallOff", stall_out, 1'b0);
        nextCycle();
        check("flushW:valid2", load_data_valid, 1'b0);
        runLoad("afterFlush", 3'b010, 32'h0000_3004, 32'h0F0F_F0F0, 0, 1'b0, 2'd2, 32'h0F0F_F0F0);

        // Async reset in the middle of WAIT, off the clock edge.
        load_valid = 1'b1;
        load_type  = 3'b010;
        load_addr  = 32'h0000_4000;
        nextCycle();
        load_valid   = 1'b0;
        data_addr_ok = 1'b1;
        nextCycle();
        data_addr_ok = 1'b0;
        #1;
        check("arst:preStall", stall_out, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("arst:req", data_req, 1'b0);
        check("arst:stall", stall_out, 1'b0);
        check("arst:valid", load_data_valid, 1'b0);
        check("arst:addr", data_addr, 32'h0);
        #3;
        rst = 1'b0;
        nextCycle();
        data_data_ok = 1'b1;
        data_rdata   = 32'h7777_7777;
        nextCycle();
        data_data_ok = 1'b0;
        #1;
        check("arst:lateValid", load_data_valid, 1'b0);
        check("arst:lateStall", stall_out, 1'b0);
        check("arst:lateData", load_data_out, 32'h0);
        nextCycle();
        check("arst:lateValid2", load_data_valid, 1'b0);
        runLoad("afterRst", 3'b100, 32'h0000_5003, 32'hA1B2_C3D4, 2, 1'b1, 2'd0, 32'h0000_00A1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/data_load_unit.md
Name: data_load_unit

Overview:
- Read-side counterpart to the MEM-stage store path, which produces byte write enables and lane-aligned store data.
- Takes a load presented in the MEM stage and issues it on the data-side request/address-ok/data-ok bus, stalling the pipeline until the data returns.
- Extracts the addressed byte or halfword from the returned 32-bit word and sign- or zero-extends it.
- Presents the result to writeback for one cycle.

Parameters:
ADDR_W, 32, width of load address and bus address.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
load_valid  in  1  MEM stage holds a load (MemReadM)
load_type  in  3  [1:0] 00 byte, 01 half, 10 word, 11 treated as word; [2] 1 = zero-extend, 0 = sign-extend
load_addr  in  ADDR_W  effective address (ALU result)
exception_in  in  4  nonzero = instruction already faulted
flush  in  1  kill the in-flight load (exception/ERET)
stall_out  out  1  freeze pipeline
adel_out  out  1  misaligned load address error
load_data_out  out  32  extended load result
load_data_valid  out  1  load_data_out valid this cycle
data_req  out  1  bus request
data_addr  out  ADDR_W  bus address, unaligned as presented
data_size  out  2  0 byte, 1 half, 2 word
data_addr_ok  in  1  request accepted
data_rdata  in  32  read word
data_data_ok  in  1  data_rdata valid

Behaviour:
- Reset (async, any state) forces:
  - state IDLE
  - data_req=0, data_addr=0, data_size=0
  - load_data_out=0, load_data_valid=0
  - killed=0, stall_out=0, adel_out=0
- Misaligned load:
  - Half with addr[0]=1, or word/11 with addr[1:0]!=0.
  - adel_out is combinational: load_valid & misaligned & exception_in==0 & state==IDLE.
- start = load_valid & exception_in==0 & !misaligned & !flush & state==IDLE.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE, start: latch addr, size, offset=addr[1:0] and sign mode; next state REQ.
  - REQ: data_req=1, addr/size held stable.
    - addr_ok=0: stay in REQ.
    - addr_ok=1 and data_ok=0: go to WAIT.
    - addr_ok=1 and data_ok=1 in the same cycle: go to DONE, or to IDLE if killed.
  - WAIT: data_req=0.
    - data_ok=1: capture the extracted result, then go to DONE, or to IDLE if killed.
  - DONE: load_data_valid=1 for exactly one cycle; next state IDLE. load_valid is ignored in DONE.
- stall_out = start | REQ | WAIT. It is low in DONE so the pipeline advances.
- Latency: with addr_ok in the first REQ cycle and data_ok one cycle later, load_data_valid asserts 3 cycles after start.
- Flush handling:
  - flush in REQ or WAIT sets killed.
  - A request is never withdrawn: req stays high until addr_ok, and the data beat is still consumed.
  - The completion is then discarded: no load_data_valid, and killed is cleared on return to IDLE.
  - flush in IDLE suppresses start.
  - flush in DONE has no effect: the data is already presented, and writeback squashes it.
- Extraction, using off = latched offset:
  - Byte: b = rdata[8*off+7 : 8*off].
  - Half: h = off[1] ? rdata[31:16] : rdata[15:0].
  - Word: rdata unchanged.
  - Extension: replicate the MSB when sign mode, else zero-fill.
- load_data_out holds its value after DONE until the next capture.
- A load with exception_in!=0 issues no request, raises no stall and raises no adel.

Decomposition:
- Shared package (mem_pkg):
  - load type encodings: LT_BYTE=2'b00, LT_HALF=2'b01, LT_WORD=2'b10, LT_UNSIGNED bit index 2
  - bus size codes
  - FSM state enum
- Sub-module load_extract: purely combinational (rdata, off, type) -> 32-bit result. Reused by any future uncached-load path.

Test Plan:
- Signed byte load, load_type=000, addr=0x80000003, rdata=0x80FF1234, data_addr_ok in REQ cycle 1, data_ok next cycle -> data_req for 1 cycle, data_size=0, data_addr=0x80000003, DONE with load_data_out=0xFFFFFF80, load_data_valid one cycle, stall_out high for exactly 3 cycles (start, REQ, WAIT).
- Unsigned half load, type=101, addr=0x...02, rdata=0x8001ABCD -> 0x00008001; signed half, type=001, addr=0x...00 -> 0xFFFFABCD.
- Misaligned word, type=010, addr=0x...06 -> adel_out=1 that cycle, data_req never asserts, stall_out=0; repeat with exception_in=4'h1 -> adel_out=0.
- Bus backpressure: addr_ok withheld 4 cycles, then addr_ok and data_ok both high in the same cycle, rdata=0x12345678, word load -> data_req high for 5 cycles with constant addr/size, no WAIT cycle, load_data_out=0x12345678.
- Flush in WAIT: flush=1 one cycle, data_ok 2 cycles later -> no load_data_valid, stall_out high until data_ok, state IDLE after; the next load starts normally.
- Async reset asserted mid-WAIT (not clock-aligned) -> data_req, stall_out and load_data_valid drop immediately; a late data_ok after reset is ignored.
